// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the scoreboarded register file.
//   state_e : init/clear/run FSM encoding
//   ZeroIdx : index of the hard-wired zero register
package regfile_scoreboard_pkg;

    typedef enum logic [1:0] {
        StReset = 2'd0,
        StClear = 2'd1,
        StReady = 2'd2
    } state_e;

    localparam int unsigned ZeroIdx = 0;

endpackage

// File: rtl/regfile_scoreboard_rd_port.sv
// One combinational read port of the scoreboarded register file.
// Forces zero data and a clear pending bit for the zero register and while the
// file is not ready. With REGFILE_BYPASS_EN defined, a same-cycle write to the
// addressed entry is forwarded.
// Ports:
//   ready_i      : file is in its run state
//   mem_i        : all array entries
//   pend_i       : all pending bits
//   rd_addr_i    : read index
//   wr_*_i       : write port (used for bypass only)
//   claim_*_i    : claim port (used for bypass only)
//   rd_data_o    : read data
//   rd_pend_o    : pending bit of the read index
module regfile_scoreboard_rd_port
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic                                 ready_i,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]     mem_i,
    input  logic [2**ADDR_W-1:0]                 pend_i,
    input  logic [ADDR_W-1:0]                    rd_addr_i,
    input  logic                                 wr_en_i,
    input  logic [ADDR_W-1:0]                    wr_addr_i,
    input  logic [DATA_W-1:0]                    wr_data_i,
    input  logic                                 claim_en_i,
    input  logic [ADDR_W-1:0]                    claim_addr_i,
    output logic [DATA_W-1:0]                    rd_data_o,
    output logic                                 rd_pend_o
);

    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZeroIdx);

    always_comb begin
        rd_data_o = '0;
        rd_pend_o = 1'b0;
        if (ready_i && (rd_addr_i != ZeroAddr)) begin
            rd_data_o = mem_i[rd_addr_i];
            rd_pend_o = pend_i[rd_addr_i];
`ifdef REGFILE_BYPASS_EN
            // wr_addr matches a nonzero rd_addr, so it is nonzero itself.
            // A claim in the same cycle re-marks the entry as pending.
            if (wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_o = wr_data_i;
                rd_pend_o = claim_en_i && (claim_addr_i == rd_addr_i);
            end
`endif
        end
    end

`ifndef REGFILE_BYPASS_EN
    logic unused_byp;
    assign unused_byp = ^{wr_en_i, wr_addr_i, wr_data_i, claim_en_i, claim_addr_i};
`endif

endmodule

// File: rtl/regfile_scoreboard.sv
// Parametrised integer register file with pending (scoreboard) bits, a
// post-reset sequential clear engine and an optional write-to-read bypass.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write forwarding).
// Ports:
//   clk_i        : clock, rising edge
//   rst_ni       : synchronous active-low reset
//   rd_addr_i    : NUM_RD packed read indices
//   rd_data_o    : NUM_RD packed read data
//   rd_pend_o    : pending bit per read port
//   wr_en_i      : write strobe from write-back
//   wr_addr_i    : write index
//   wr_data_i    : write data
//   claim_en_i   : decode claims claim_addr_i as a future destination
//   claim_addr_i : index to mark pending
//   init_busy_o  : high during reset and while the clear engine runs
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned NUM_RD = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0]   rd_data_o,
    output logic [NUM_RD-1:0]          rd_pend_o,
    input  logic                       wr_en_i,
    input  logic [ADDR_W-1:0]          wr_addr_i,
    input  logic [DATA_W-1:0]          wr_data_i,
    input  logic                       claim_en_i,
    input  logic [ADDR_W-1:0]          claim_addr_i,
    output logic                       init_busy_o
);

    localparam int unsigned DEPTH = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZeroAddr = ADDR_W'(ZeroIdx);
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    state_e                        state_q;
    logic [ADDR_W-1:0]             cnt_q;
    logic                          busy_q;
    logic [DEPTH-1:0]              pend_q;
    logic [DEPTH-1:0]              pend_d;
    logic [DEPTH-1:0][DATA_W-1:0]  mem_q;
    logic                          ready;

    assign ready       = (state_q == StReady);
    assign init_busy_o = busy_q;

    // Claim is applied after the write release so the new producer wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_en_i && (wr_addr_i != ZeroAddr)) begin
            pend_d[wr_addr_i] = 1'b0;
        end
        if (claim_en_i && (claim_addr_i != ZeroAddr)) begin
            pend_d[claim_addr_i] = 1'b1;
        end
    end

    // Init/clear/run FSM; pending bits only move in the run state.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StReset;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            pend_q  <= '0;
        end else begin
            case (state_q)
                StReset: begin
                    state_q <= StClear;
                    cnt_q   <= '0;
                    busy_q  <= 1'b1;
                end
                StClear: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastAddr) begin
                        state_q <= StReady;
                        busy_q  <= 1'b0;
                    end
                end
                StReady: begin
                    pend_q <= pend_d;
                end
                default: begin
                    state_q <= StReset;
                    busy_q  <= 1'b1;
                end
            endcase
        end
    end

    // Array has no reset of its own: the clear engine defines every entry.
    always_ff @(posedge clk_i) begin
        if (rst_ni) begin
            if (state_q == StClear) begin
                mem_q[cnt_q] <= '0;
            end else if (ready && wr_en_i && (wr_addr_i != ZeroAddr)) begin
                mem_q[wr_addr_i] <= wr_data_i;
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        regfile_scoreboard_rd_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_rd_port (
            .ready_i      (ready),
            .mem_i        (mem_q),
            .pend_i       (pend_q),
            .rd_addr_i    (rd_addr_i[k*ADDR_W +: ADDR_W]),
            .wr_en_i      (wr_en_i),
            .wr_addr_i    (wr_addr_i),
            .wr_data_i    (wr_data_i),
            .claim_en_i   (claim_en_i),
            .claim_addr_i (claim_addr_i),
            .rd_data_o    (rd_data_o[k*DATA_W +: DATA_W]),
            .rd_pend_o    (rd_pend_o[k])
        );
    end

endmodule
